instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction parser, immediate generator and control unit in the core. Owns the program counter and issues word fetches to an instruction memory with variable latency using a request/response handshake. Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready interface. Accepts branch redirects from the execute side and flushes stale fetches.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/instr_fetch_unit_if.sv | 44 ++++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch control states (HALT only with FETCH_MISALIGN_CHECK_EN)
//   fetch_entry_t : instruction buffer entry {inst, pc}
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
package fetch_pkg;

  localparam int unsigned ILEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned PC_W       = 64;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;
`endif

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory request/response, redirect and decode-side
// valid/ready signals of the fetch stage.
//   master : fetch unit view (drives imem_req/addr and the out_* bundle)
//   slave  : memory/execute/decode view
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds misalign_err)
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 64
) ();
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_err;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, misalign_err,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, misalign_err,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
`else
  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small flop-based instruction buffer with synchronous flush.
//   clk, reset         : clock, async active-high reset
//   flush              : empties the buffer (wins over push/pop)
//   push, push_data    : write an entry (accepted when not full or popping)
//   pop, pop_data      : head entry, removed on pop when not empty
//   full, empty, count : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // a full buffer can still take a word when the head leaves in the same cycle
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues one word fetch at a time to the
// instruction memory, buffers returned words with their PCs and hands them to
// decode; branch redirects flush the buffer and drop stale responses.
//   clk, reset : clock, async active-high reset
//   bus        : instr_fetch_unit_if.master (imem req/resp, redirect, out_*)
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- a misaligned redirect
// target sets sticky misalign_err and parks the unit in HALT until reset.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN       = 64,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            fire;
  logic            credit;
  logic            redirect_live;
  logic            outstanding_next;
  logic            push;
  logic            pop;
  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_data;
  fetch_entry_t    pop_data;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            err_q, err_d;
`endif

  // buffer occupancy plus the in-flight request must stay below depth
  assign credit        = (fifo_count + CW'(state_q != ISSUE)) < CW'(FIFO_DEPTH);
  assign bus.imem_req  = !reset && (state_q == ISSUE) && credit && !fifo_full;
  assign bus.imem_addr = pc_q;
  assign fire          = bus.imem_req && bus.imem_ready;

  assign pop           = !fifo_empty && bus.out_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_inst  = pop_data.inst;
  assign bus.out_pc    = XLEN'(pop_data.pc);
  assign push_data     = '{inst: bus.imem_rdata, pc: PC_W'(req_pc_q)};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_live    = bus.redirect && (state_q != HALT);
  assign bus.misalign_err = err_q;
`else
  assign redirect_live    = bus.redirect;
`endif

  // next state, PC and buffer control
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    req_pc_d         = req_pc_q;
    push             = 1'b0;
    flush            = 1'b0;
    outstanding_next = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    err_d            = err_q;
`endif

    unique case (state_q)
      ISSUE: begin
        if (fire) begin
          req_pc_d         = pc_q;
          pc_d             = pc_q + XLEN'(INST_BYTES);
          state_d          = WAIT;
          outstanding_next = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push    = 1'b1;
          state_d = ISSUE;
        end else begin
          outstanding_next = 1'b1;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          state_d = err_q ? HALT : ISSUE;
`else
          state_d = ISSUE;
`endif
        end else begin
          outstanding_next = 1'b1;
        end
      end
      default: ;
    endcase

    // redirect overrides push/pop; a still-pending response must be dropped
    if (redirect_live) begin
      flush = 1'b1;
      push  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        pc_d    = pc_q;
        state_d = outstanding_next ? DROP : HALT;
      end else begin
        pc_d    = bus.redirect_pc;
        state_d = outstanding_next ? DROP : (err_q ? HALT : ISSUE);
      end
`else
      pc_d    = bus.redirect_pc & ~XLEN'(INST_BYTES - 1);
      state_d = outstanding_next ? DROP : ISSUE;
`endif
    end
  end

  // control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ISSUE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // sticky misalignment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit with a
// queue-based reference model and a variable-latency memory responder.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds the halt scenario).
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instr_fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  // reference model: buffered entries, fetch PC, outstanding request (0 none, 1 live, 2 stale)
  ent_t        m_q[$];
  logic [63:0] m_pc;
  logic [63:0] m_req_pc;
  int          m_out;
  bit          m_err;
  bit          m_halted;

  // memory responder
  bit          mem_pending;
  int          mem_wait;
  logic [31:0] mem_data;
  int          lat_lo = 1;
  int          lat_hi = 1;

  logic [63:0] seen[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [63:0] seen_at(input int i);
    if (i < seen.size()) return seen[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic bit exp_req();
    return !m_halted && (m_out == 0) && (m_q.size() < int'(DEPTH));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = RST_PC;
    m_req_pc = '0;
    m_out    = 0;
    m_err    = 0;
    m_halted = 0;
  endtask

  task automatic idle_inputs();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
  endtask

  // one clock cycle: compare at negedge, drive inputs, advance model and memory
  task automatic step(input bit rdy, input bit ordy, input bit redir, input logic [63:0] tgt);
    bit rv, e_req, fire, resp, pop;
    @(negedge clk);
    rv = 0;
    if (mem_pending) begin
      mem_wait--;
      rv = (mem_wait <= 0);
    end
    e_req = exp_req();
    check("imem_req", bus.imem_req, e_req);
    if (e_req) check("imem_addr", bus.imem_addr, m_pc);
    check("out_valid", bus.out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("out_inst", bus.out_inst, m_q[0].inst);
      check("out_pc", bus.out_pc, m_q[0].pc);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_err", bus.misalign_err, m_err);
`endif
    bus.imem_ready  = rdy && !mem_pending;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_data : 32'($urandom());
    bus.redirect    = redir;
    bus.redirect_pc = tgt;
    bus.out_ready   = ordy;
    if (bus.out_valid && ordy) seen.push_back(bus.out_pc);
    #1;
    fire = e_req && rdy && !mem_pending;
    resp = rv && (m_out != 0);
    pop  = (m_q.size() > 0) && ordy;
    if (redir && !m_halted) begin
      m_q.delete();
      if (resp) m_out = 0;
      if (fire || m_out == 1) m_out = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) m_err = 1;
      else m_pc = tgt;
`else
      m_pc = {tgt[63:2], 2'b00};
`endif
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        if (m_out == 1) m_q.push_back('{word_of(m_req_pc), m_req_pc});
        m_out = 0;
      end
      if (fire) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 64'd4;
        m_out    = 1;
      end
    end
    if (m_err && m_out == 0) m_halted = 1;
    if (rv) mem_pending = 0;
    if (bus.imem_req && bus.imem_ready) begin
      mem_pending = 1;
      mem_wait    = $urandom_range(lat_hi, lat_lo);
      mem_data    = word_of(bus.imem_addr);
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input bit keep_mem);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    if (!keep_mem) mem_pending = 0;
    repeat (3) begin
      #1;
      check("rst_imem_req", bus.imem_req, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_inst", bus.out_inst, 32'h0);
      check("rst_out_pc", bus.out_pc, 64'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misalign_err", bus.misalign_err, 1'b0);
`endif
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 1'b1, 1'b0, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t;
    bit          found;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    mem_pending = 0;
    mem_wait    = 0;
    mem_data    = '0;

    // sequential fetch with single-cycle memory
    do_reset(1'b0);
    lat_lo = 1; lat_hi = 1;
    seen.delete();
    repeat (8) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("t1_count", 64'(seen.size()), 64'd3);
    check("t1_pc0", seen_at(0), 64'h1000);
    check("t1_pc1", seen_at(1), 64'h1004);
    check("t1_pc2", seen_at(2), 64'h1008);

    // decode stall fills the buffer, then drains in order
    repeat (10) step(1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    check("t2_full_valid", bus.out_valid, 1'b1);
    check("t2_full_req", bus.imem_req, 1'b0);
    seen.delete();
    repeat (12) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("t2_first", seen_at(0), 64'h100C);
    check("t2_second", seen_at(1), 64'h1010);
    for (int i = 1; i < seen.size(); i++) check("t2_order", seen[i], seen[i-1] + 64'd4);

    // redirect while a 3-cycle fetch is outstanding
    lat_lo = 3; lat_hi = 3;
    drain();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0);
      found = (m_out == 1);
    end
    check("t3_setup", found, 1'b1);
    step(1'b1, 1'b1, 1'b1, 64'h2000);
    seen.delete();
    for (int i = 0; i < 30 && seen.size() == 0; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("t3_target", seen_at(0), 64'h2000);

    // redirect coincident with a response and a pop
    lat_lo = 1; lat_hi = 1;
    drain();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 1'b0, 64'h0);
      found = (m_q.size() == 1) && (m_out == 1);
    end
    check("t4_setup", found, 1'b1);
    step(1'b1, 1'b1, 1'b1, 64'h3000);
    #1;
    check("t4_flushed", bus.out_valid, 1'b0);
    seen.delete();
    for (int i = 0; i < 30 && seen.size() == 0; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("t4_target", seen_at(0), 64'h3000);

    // PC wrap at the top of the address space
    drain();
    step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    seen.delete();
    repeat (10) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("t5_top", seen_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_wrap", seen_at(1), 64'h0);

    // reset mid-transaction; the late response must be ignored
    lat_lo = 4; lat_hi = 4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0);
      found = (m_out == 1) && (mem_wait == 4);
    end
    check("t6_setup", found, 1'b1);
    do_reset(1'b1);
    seen.delete();
    repeat (4) step(1'b1, 1'b1, 1'b0, 64'h0);
    #1;
    check("t6_late_ignored", bus.out_valid, 1'b0);
    lat_lo = 1; lat_hi = 1;
    repeat (8) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("t6_first", seen_at(0), RST_PC);

    // randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      t = {32'($urandom()), 32'($urandom())};
      if ($urandom_range(3, 0) == 0) t = {32'hFFFF_FFFF, 16'hFFFF, t[15:0]};
`ifdef FETCH_MISALIGN_CHECK_EN
      t[1:0] = 2'b00;
`endif
      step($urandom_range(3, 0) != 0, $urandom_range(4, 0) >= 2,
           $urandom_range(19, 0) == 0, t);
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // misaligned redirect halts fetch until reset
    do_reset(1'b0);
    lat_lo = 2; lat_hi = 2;
    repeat (6) step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h2002);
    #1;
    check("t8_err", bus.misalign_err, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h4000);
    repeat (10) step(1'b1, 1'b1, 1'b0, 64'h0);
    #1;
    check("t8_halt_req", bus.imem_req, 1'b0);
    check("t8_err_sticky", bus.misalign_err, 1'b1);
    do_reset(1'b0);
    #1;
    check("t8_err_cleared", bus.misalign_err, 1'b0);
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
